// File: rtl/updown_digit_counter_pkg.sv
// Shared types for the up/down digit counter: FSM states and tick direction.
package updown_digit_counter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RIPPLE = 1'b1
  } state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

endpackage

// File: rtl/updown_digit_counter_digit_step.sv
// digit_step: combinational modulo-L step of a single digit.
// up and dn together (or neither) leave the digit unchanged with no carry.
module digit_step #(
  parameter int L = 10,
  parameter int N = $clog2(L)
) (
  input  logic [N-1:0] v,
  input  logic         up,
  input  logic         dn,
  output logic [N-1:0] nv,
  output logic         carry
);

  localparam logic [N-1:0] MAXV = N'(L - 1);

  // Wrap at L-1 going up and at 0 going down; both wraps raise carry/borrow.
  always_comb begin
    nv    = v;
    carry = 1'b0;
    if (up && !dn) begin
      if (v == MAXV) begin
        nv    = '0;
        carry = 1'b1;
      end else begin
        nv = v + N'(1);
      end
    end else if (dn && !up) begin
      if (v == '0) begin
        nv    = MAXV;
        carry = 1'b1;
      end else begin
        nv = v - N'(1);
      end
    end
  end

endmodule

// File: rtl/updown_digit_counter.sv
// updown_digit_counter: multi-digit modulo-L up/down counter whose carries
// and borrows ripple upward one digit per clock through a single shared
// digit_step. Optional macro COUNTER_SATURATE_EN turns whole-counter wrap
// into a hold plus a one-cycle wrap flag.
module updown_digit_counter
  import updown_digit_counter_pkg::*;
#(
  parameter  int L      = 10,
  parameter  int DIGITS = 4,
  localparam int N      = $clog2(L)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_up,
  input  logic                tick_dn,
  input  logic                clear,
  input  logic                load,
  input  logic [DIGITS*N-1:0] load_val,
  output logic [DIGITS*N-1:0] count,
  output logic                ready,
  output logic                wrap
);

  localparam int           IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [N-1:0] MAXV = N'(L - 1);

  state_t                   r_state, w_state_nxt;
  dir_t                     r_dir, w_dir_nxt;
  logic [IDXW-1:0]          r_idx, w_idx_nxt;
  logic [DIGITS-1:0][N-1:0] r_count, w_count_nxt, w_ld;
  logic                     r_wrap, w_wrap_nxt;

  logic [IDXW-1:0] w_sel;
  logic [N-1:0]    w_v, w_nv;
  logic            w_up, w_dn, w_carry, w_sat;

  assign count = r_count;
  assign ready = (r_state == ST_IDLE);
  assign wrap  = r_wrap;

  // Step operand: digit 0 on a fresh tick, digit idx while rippling.
  always_comb begin
    w_sel = '0;
    w_up  = tick_up & ~tick_dn;
    w_dn  = tick_dn & ~tick_up;
    if (r_state == ST_RIPPLE) begin
      w_sel = r_idx;
      w_up  = (r_dir == DIR_UP);
      w_dn  = (r_dir == DIR_DN);
    end
    w_v = r_count[w_sel];
  end

  digit_step #(.L(L), .N(N)) u_step (
    .v     (w_v),
    .up    (w_up),
    .dn    (w_dn),
    .nv    (w_nv),
    .carry (w_carry)
  );

  // Load image: out-of-range digits are forced to zero.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      w_ld[i] = (int'(load_val[i*N +: N]) >= L) ? '0 : load_val[i*N +: N];
    end
  end

`ifdef COUNTER_SATURATE_EN
  logic w_lim_up, w_lim_dn;

  // Detect a tick that would wrap the whole counter.
  always_comb begin
    w_lim_up = 1'b1;
    w_lim_dn = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_count[i] != MAXV) w_lim_up = 1'b0;
      if (r_count[i] != '0)   w_lim_dn = 1'b0;
    end
  end

  assign w_sat = (w_up & w_lim_up) | (w_dn & w_lim_dn);
`else
  assign w_sat = 1'b0;
`endif

  // Next state: clear beats load beats tick/ripple; wrap is a 1-cycle pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_dir_nxt   = r_dir;
    w_wrap_nxt  = 1'b0;
    if (clear) begin
      w_count_nxt = '0;
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end else if (load) begin
      w_count_nxt = w_ld;
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_up | w_dn) begin
            w_dir_nxt = w_up ? DIR_UP : DIR_DN;
            if (w_sat) begin
              w_wrap_nxt = 1'b1;
            end else begin
              w_count_nxt[0] = w_nv;
              if (w_carry) begin
                if (DIGITS > 1) begin
                  w_state_nxt = ST_RIPPLE;
                  w_idx_nxt   = IDXW'(1);
                end else begin
                  w_wrap_nxt  = 1'b1;
                end
              end
            end
          end
        end
        ST_RIPPLE: begin
          w_count_nxt[r_idx] = w_nv;
          if (w_carry && (int'(r_idx) != DIGITS - 1)) begin
            w_idx_nxt = r_idx + IDXW'(1);
          end else begin
            w_wrap_nxt  = w_carry;
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // State, digit, index, direction and wrap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_dir   <= DIR_UP;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_idx   <= w_idx_nxt;
      r_dir   <= w_dir_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

endmodule

// File: tb/tb_updown_digit_counter.sv
// Bench for updown_digit_counter (L=10, DIGITS=3). The reference tracks the
// counter as an integer: an accepted tick fixes the old and new values, and
// while rippling the visible count is the low k digits of the new value over
// the high digits of the old one.
module tb_updown_digit_counter;

  localparam int L   = 10;
  localparam int D   = 3;
  localparam int N   = 4;
  localparam int MOD = 1000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tick_up = 1'b0, tick_dn = 1'b0, clear = 1'b0, load = 1'b0;
  logic [D*N-1:0] load_val = '0;
  logic [D*N-1:0] count;
  logic           ready, wrap;

  int n_chk  = 0;
  int n_pass = 0;

  // reference state
  int m_disp, m_old, m_new, m_touch, m_done;
  bit m_busy, m_wrap, m_wflag;
  bit sat_en;

  updown_digit_counter #(.L(L), .DIGITS(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_up  (tick_up),
    .tick_dn  (tick_dn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .ready    (ready),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic int pw(int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * L;
    return r;
  endfunction

  function automatic logic [D*N-1:0] enc(int v);
    logic [D*N-1:0] r = '0;
    for (int i = 0; i < D; i++) r[i*N +: N] = N'((v / pw(i)) % L);
    return r;
  endfunction

  function automatic int dec_ld(logic [D*N-1:0] lv);
    int s = 0;
    for (int i = 0; i < D; i++)
      if (int'(lv[i*N +: N]) < L) s = s + int'(lv[i*N +: N]) * pw(i);
    return s;
  endfunction

  function automatic int partial(int oldv, int newv, int k);
    return (newv % pw(k)) + (oldv / pw(k)) * pw(k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_disp = 0; m_busy = 0; m_wrap = 0; m_done = 0; m_touch = 0;
  endtask

  task automatic model_step(input bit tu, input bit td, input bit clr, input bit ld,
                            input logic [D*N-1:0] lv);
    int tr;
    m_wrap = 0;
    if (clr) begin
      m_disp = 0; m_busy = 0;
    end else if (ld) begin
      m_disp = dec_ld(lv); m_busy = 0;
    end else if (m_busy) begin
      m_done++;
      if (m_done == m_touch) begin
        m_busy = 0; m_disp = m_new; m_wrap = m_wflag;
      end else begin
        m_disp = partial(m_old, m_new, m_done);
      end
    end else if (tu ^ td) begin
      m_old = m_disp;
      m_new = tu ? (m_old + 1) % MOD : (m_old + MOD - 1) % MOD;
      tr = 0;
      while (tr < D && ((m_old / pw(tr)) % L) == (tu ? L - 1 : 0)) tr++;
      m_wflag = (tr == D);
      m_touch = (tr + 1 > D) ? D : tr + 1;
      if (sat_en && m_wflag) begin
        m_wrap = 1;
      end else begin
        m_done = 1;
        if (m_touch == 1) begin
          m_disp = m_new; m_wrap = m_wflag;
        end else begin
          m_busy = 1; m_disp = partial(m_old, m_new, 1);
        end
      end
    end
  endtask

  // One clock: drive, clock, advance the reference, compare every output.
  task automatic cyc(input bit tu, input bit td, input bit clr, input bit ld,
                     input logic [D*N-1:0] lv);
    tick_up = tu; tick_dn = td; clear = clr; load = ld; load_val = lv;
    @(posedge clk);
    #1;
    model_step(tu, td, clr, ld, lv);
    chk("count", 32'(count), 32'(enc(m_disp)));
    chk("ready", 32'(ready), 32'(!m_busy));
    chk("wrap",  32'(wrap),  32'(m_wrap));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, '0);
  endtask

  initial begin
    logic [D*N-1:0] lv;
    int r;
    bit tu, td, clr, ld;
`ifdef COUNTER_SATURATE_EN
    sat_en = 1;
`else
    sat_en = 0;
`endif
    model_reset();
    #12;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_wrap",  32'(wrap),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 099 + 1: one digit per clock
    cyc(0, 0, 0, 1, 12'h099);
    cyc(1, 0, 0, 0, '0);
    chk("r099_t1", 32'(count), 32'h090);
    chk("r099_rdy1", 32'(ready), 32'h0);
    idle();
    chk("r099_t2", 32'(count), 32'h000);
    idle();
    chk("r099_t3", 32'(count), 32'h100);
    chk("r099_rdy3", 32'(ready), 32'h1);
    chk("r099_wrap", 32'(wrap), 32'h0);

    // 999 + 1 with a second tick during the ripple
    cyc(0, 0, 0, 1, 12'h999);
    cyc(1, 0, 0, 0, '0);
`ifdef COUNTER_SATURATE_EN
    chk("sat999_count", 32'(count), 32'h999);
    chk("sat999_wrap",  32'(wrap),  32'h1);
    cyc(0, 0, 0, 0, '0);
    chk("sat999_wrap_off", 32'(wrap), 32'h0);
`else
    cyc(1, 0, 0, 0, '0);
    idle();
    chk("w999_count", 32'(count), 32'h000);
    chk("w999_wrap",  32'(wrap),  32'h1);
    chk("w999_ready", 32'(ready), 32'h1);
    idle();
    chk("w999_wrap_off", 32'(wrap), 32'h0);
`endif

    // 000 - 1
    cyc(0, 0, 1, 0, '0);
    cyc(0, 1, 0, 0, '0);
`ifdef COUNTER_SATURATE_EN
    chk("sat000_count", 32'(count), 32'h000);
    chk("sat000_wrap",  32'(wrap),  32'h1);
`else
    cyc(0, 1, 0, 0, '0);
    idle();
    chk("w000_count", 32'(count), 32'h999);
    chk("w000_wrap",  32'(wrap),  32'h1);
`endif
    idle();

    // simultaneous ticks cancel
    cyc(0, 0, 0, 1, 12'h456);
    cyc(1, 1, 0, 0, '0);
    chk("both_count", 32'(count), 32'h456);
    chk("both_ready", 32'(ready), 32'h1);

    // clear aborts a ripple
    cyc(0, 0, 0, 1, 12'h399);
    cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, '0);
    chk("clr_count", 32'(count), 32'h000);
    chk("clr_ready", 32'(ready), 32'h1);
    chk("clr_wrap",  32'(wrap),  32'h0);

    // out-of-range load digit, load+clear
    cyc(0, 0, 0, 1, 12'hC53);
    chk("ld_sanit", 32'(count), 32'h053);
    cyc(0, 0, 1, 1, 12'h777);
    chk("ld_clr", 32'(count), 32'h000);

    // async reset in the middle of a ripple
    cyc(0, 0, 0, 1, 12'h099);
    cyc(1, 0, 0, 0, '0);
    tick_up = 0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_count", 32'(count), 32'h0);
    chk("rstmid_ready", 32'(ready), 32'h1);
    chk("rstmid_wrap",  32'(wrap),  32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, '0);
    chk("rstmid_tick", 32'(count), 32'h001);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r   = $urandom_range(0, 99);
      clr = (r < 2);
      ld  = (r >= 2 && r < 7);
      tu  = ($urandom_range(0, 2) == 0);
      td  = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < D; i++) begin
        case ($urandom_range(0, 3))
          0:       lv[i*N +: N] = 4'd0;
          1:       lv[i*N +: N] = 4'd9;
          default: lv[i*N +: N] = 4'($urandom_range(0, 15));
        endcase
      end
      cyc(tu, td, clr, ld, lv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
